io_bus_arbiter: RTL and testbench

//  Shares the single IO bus (cs/wr/rd/addr/wr_data/rd_data into the IO controller) between two masters:
//  M0 (CPU core) and M1 (DMA/debug engine). Each master posts one command with a one-cycle req pulse.
//  The arbiter buffers one pending command per master and serves them round-robin, one bus transaction each.
//  It returns a one-cycle ack per command, plus registered read data for reads.

---
 rtl/io_bus_arbiter.sv | 143 ++++++++++++++
 tb/tb_io_bus_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/io_bus_arbiter.sv
// Two-master round-robin arbiter for the shared IO bus: one buffered command per master,
// one bus transaction per command, one-cycle ack and registered read data per master.
module io_bus_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wr_data,
  output logic              m0_busy,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rd_data,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wr_data,
  output logic              m1_busy,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rd_data,
  output logic              bus_cs,
  output logic              bus_wr,
  output logic              bus_rd,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wr_data,
  input  logic [DATA_W-1:0] bus_rd_data,
  output logic [1:0]        o_dbg_state
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_ACK   = 2'd3;

  localparam logic [2:0] LAT_M1 = (RD_LATENCY > 0) ? 3'(RD_LATENCY - 1) : 3'd0;

  logic [1:0]        r_state;
  logic [1:0]        r_pend;
  logic [1:0]        r_cmd_wr;
  logic [ADDR_W-1:0] r_cmd_addr [2];
  logic [DATA_W-1:0] r_cmd_wd   [2];
  logic [DATA_W-1:0] r_rd_data  [2];
  logic              r_gnt;
  logic              r_last;
  logic [2:0]        r_cnt;

  logic [1:0]        w_req;
  logic [1:0]        w_wr;
  logic [ADDR_W-1:0] w_addr [2];
  logic [DATA_W-1:0] w_wd   [2];
  logic              w_pick;
  logic              w_issue;
  logic              w_cur_wr;

  assign w_req     = {m1_req, m0_req};
  assign w_wr      = {m1_wr, m0_wr};
  assign w_addr[0] = m0_addr;
  assign w_addr[1] = m1_addr;
  assign w_wd[0]   = m0_wr_data;
  assign w_wd[1]   = m1_wr_data;

  // With both pending, the master that did not win last time goes next.
  assign w_pick   = (&r_pend) ? ~r_last : r_pend[1];
  assign w_issue  = (r_state == ST_ISSUE);
  assign w_cur_wr = r_cmd_wr[r_gnt];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_pend       <= 2'b00;
      r_cmd_wr     <= 2'b00;
      r_cmd_addr   <= '{default: '0};
      r_cmd_wd     <= '{default: '0};
      r_rd_data    <= '{default: '0};
      r_gnt        <= 1'b0;
      r_last       <= 1'b1;
      r_cnt        <= 3'd0;
    end else begin
      // A pending slot (including one being acked) ignores new requests.
      for (int n = 0; n < 2; n++) begin
        if ((r_state == ST_ACK) && (r_gnt == 1'(n))) begin
          r_pend[n] <= 1'b0;
        end else if (w_req[n] && !r_pend[n]) begin
          r_pend[n]     <= 1'b1;
          r_cmd_wr[n]   <= w_wr[n];
          r_cmd_addr[n] <= w_addr[n];
          r_cmd_wd[n]   <= w_wd[n];
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (|r_pend) begin
            r_gnt   <= w_pick;
            r_last  <= w_pick;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (w_cur_wr) begin
            r_state <= ST_ACK;
          end else if (RD_LATENCY == 0) begin
            r_rd_data[r_gnt] <= bus_rd_data;
            r_state          <= ST_ACK;
          end else begin
            r_cnt   <= LAT_M1;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt == 3'd0) begin
            r_rd_data[r_gnt] <= bus_rd_data;
            r_state          <= ST_ACK;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Bus is driven only in ISSUE, so each command produces exactly one strobe.
  assign bus_cs      = w_issue;
  assign bus_wr      = w_issue & w_cur_wr;
  assign bus_rd      = w_issue & ~w_cur_wr;
  assign bus_addr    = w_issue ? r_cmd_addr[r_gnt] : '0;
  assign bus_wr_data = (w_issue && w_cur_wr) ? r_cmd_wd[r_gnt] : '0;

  assign m0_busy     = r_pend[0];
  assign m1_busy     = r_pend[1];
  assign m0_ack      = (r_state == ST_ACK) && !r_gnt;
  assign m1_ack      = (r_state == ST_ACK) && r_gnt;
  assign m0_rd_data  = r_rd_data[0];
  assign m1_rd_data  = r_rd_data[1];
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Bench for io_bus_arbiter: three instances (read latency 1, 3, 0) share one stimulus stream
// and are compared every cycle against a transaction-timeline model, plus directed literal checks.
module tb_io_bus_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- stimulus signals ----------------
  logic        req [2];
  logic        wr  [2];
  logic [31:0] addr[2];
  logic [31:0] wd  [2];
  logic [31:0] bdata;

  // ---------------- DUT outputs per instance ----------------
  logic [2:0]  busy0_a, busy1_a, ack0_a, ack1_a, cs_a, bwr_a, brd_a;
  logic [31:0] rd0_a [3];
  logic [31:0] rd1_a [3];
  logic [31:0] baddr_a [3];
  logic [31:0] bwd_a [3];
  logic [1:0]  dbg_a [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    io_bus_arbiter #(
      .ADDR_W(32), .DATA_W(32),
      .RD_LATENCY((g == 0) ? 1 : (g == 1) ? 3 : 0)
    ) dut (
      .clk(clk), .reset(reset),
      .m0_req(req[0]), .m0_wr(wr[0]), .m0_addr(addr[0]), .m0_wr_data(wd[0]),
      .m0_busy(busy0_a[g]), .m0_ack(ack0_a[g]), .m0_rd_data(rd0_a[g]),
      .m1_req(req[1]), .m1_wr(wr[1]), .m1_addr(addr[1]), .m1_wr_data(wd[1]),
      .m1_busy(busy1_a[g]), .m1_ack(ack1_a[g]), .m1_rd_data(rd1_a[g]),
      .bus_cs(cs_a[g]), .bus_wr(bwr_a[g]), .bus_rd(brd_a[g]),
      .bus_addr(baddr_a[g]), .bus_wr_data(bwd_a[g]), .bus_rd_data(bdata),
      .o_dbg_state(dbg_a[g])
    );
  end

  // ---------------- scoreboard counters ----------------
  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string nm, input logic [66:0] act, input logic [66:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
  endtask

  // ---------------- model: per-instance transaction timeline ----------------
  int          lat [3] = '{1, 3, 0};
  bit          m_pend  [3][2];
  bit          m_cwr   [3][2];
  logic [31:0] m_caddr [3][2];
  logic [31:0] m_cwd   [3][2];
  logic [31:0] m_rdata [3][2];
  bit          m_last  [3];
  bit          m_active[3];
  bit          m_cur   [3];
  int          m_strobe[3];
  int          m_ackc  [3];

  // event logs used by the directed literal checks
  int          strobe_cnt [3];
  int          strobe_cyc [3];
  logic [31:0] strobe_addr[3];
  logic [31:0] strobe_wd  [3];
  int          ack_cnt [3][2];
  int          ack_cyc [3][2];
  logic [31:0] ack_rd  [3][2];
  logic [31:0] strobe_log[$];

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      bit e_cs, e_wr, old_act;
      bit old_p [2];
      int c;
      c = m_cur[k];
      e_cs = m_active[k] && (cyc == m_strobe[k]);
      e_wr = e_cs && m_cwr[k][c];
      if (chk_en) begin
        check($sformatf("bus[%0d]", k),
              {cs_a[k], bwr_a[k], brd_a[k], baddr_a[k], bwd_a[k]},
              {e_cs, e_wr, e_cs && !e_wr, e_cs ? m_caddr[k][c] : 32'h0,
               e_wr ? m_cwd[k][c] : 32'h0});
        check($sformatf("busy_ack[%0d]", k),
              67'({busy1_a[k], busy0_a[k], ack1_a[k], ack0_a[k]}),
              67'({m_pend[k][1], m_pend[k][0],
                   m_active[k] && cyc == m_ackc[k] && c == 1,
                   m_active[k] && cyc == m_ackc[k] && c == 0}));
        check($sformatf("rd0[%0d]", k), 67'(rd0_a[k]), 67'(m_rdata[k][0]));
        check($sformatf("rd1[%0d]", k), 67'(rd1_a[k]), 67'(m_rdata[k][1]));
        if (cs_a[k]) begin
          strobe_cnt[k]++;
          strobe_cyc[k]  = cyc;
          strobe_addr[k] = baddr_a[k];
          strobe_wd[k]   = bwd_a[k];
          if (k == 0) strobe_log.push_back(baddr_a[k]);
        end
        if (ack0_a[k]) begin ack_cnt[k][0]++; ack_cyc[k][0] = cyc; ack_rd[k][0] = rd0_a[k]; end
        if (ack1_a[k]) begin ack_cnt[k][1]++; ack_cyc[k][1] = cyc; ack_rd[k][1] = rd1_a[k]; end
      end

      // advance model using this cycle's inputs
      if (reset) begin
        m_pend[k]   = '{0, 0};
        m_rdata[k]  = '{32'h0, 32'h0};
        m_last[k]   = 1'b1;
        m_active[k] = 1'b0;
      end else begin
        old_act = m_active[k];
        old_p   = m_pend[k];
        if (old_act && cyc == m_ackc[k]) begin
          m_pend[k][c] = 1'b0;
          m_active[k]  = 1'b0;
        end else if (old_act && !m_cwr[k][c] && cyc == m_ackc[k] - 1) begin
          m_rdata[k][c] = bdata;
        end
        if (!old_act && (old_p[0] || old_p[1])) begin
          m_cur[k]    = (old_p[0] && old_p[1]) ? !m_last[k] : old_p[1];
          m_last[k]   = m_cur[k];
          m_active[k] = 1'b1;
          m_strobe[k] = cyc + 1;
          m_ackc[k]   = cyc + 2 + (m_cwr[k][m_cur[k]] ? 0 : lat[k]);
        end
        for (int n = 0; n < 2; n++) begin
          if (req[n] && !old_p[n]) begin
            m_pend[k][n]  = 1'b1;
            m_cwr[k][n]   = wr[n];
            m_caddr[k][n] = addr[n];
            m_cwd[k][n]   = wd[n];
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_cmd(input int m, input bit w, input logic [31:0] a, input logic [31:0] d);
    req[m] = 1'b1; wr[m] = w; addr[m] = a; wd[m] = d;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int t, s0, a0, a1;
    for (int n = 0; n < 2; n++) begin req[n] = 0; wr[n] = 0; addr[n] = 0; wd[n] = 0; end
    bdata = 32'h0;
    step(3);
    reset = 1'b0;
    chk_en = 1'b1;
    check("reset_outs",
          67'({cs_a, bwr_a, brd_a, busy0_a, busy1_a, ack0_a, ack1_a, baddr_a[0], rd1_a[1]}),
          67'(0));

    // 1: M0 write
    t = cyc; s0 = strobe_cnt[0];
    set_cmd(0, 1'b1, 32'h0000_0004, 32'h0000_00A5);
    step(1); req[0] = 1'b0;
    step(8);
    check("t1_strobe_cyc", 67'(strobe_cyc[0]), 67'(t + 2));
    check("t1_strobe_cnt", 67'(strobe_cnt[0] - s0), 67'(1));
    check("t1_addr", 67'(strobe_addr[0]), 67'(32'h4));
    check("t1_wdata", 67'(strobe_wd[0]), 67'(32'hA5));
    check("t1_ack_cyc", 67'(ack_cyc[0][0]), 67'(t + 3));

    // 2: M1 read, latency 1
    t = cyc;
    set_cmd(1, 1'b0, 32'h0000_0008, 32'hFFFF_FFFF);
    step(1); req[1] = 1'b0;
    step(2); bdata = 32'h1234_5678;
    step(1); bdata = 32'h0;
    step(8);
    check("t2_strobe_cyc", 67'(strobe_cyc[0]), 67'(t + 2));
    check("t2_rd_wdata", 67'(strobe_wd[0]), 67'(0));
    check("t2_ack_cyc", 67'(ack_cyc[0][1]), 67'(t + 4));
    check("t2_rdata", 67'(ack_rd[0][1]), 67'(32'h1234_5678));

    // 3: simultaneous requests, twice
    strobe_log.delete();
    for (int r = 0; r < 2; r++) begin
      t = cyc;
      set_cmd(0, 1'b1, 32'h10, 32'h111);
      set_cmd(1, 1'b1, 32'h20, 32'h222);
      step(1); req[0] = 1'b0; req[1] = 1'b0;
      step(10);
      check("t3_m0_ack_cyc", 67'(ack_cyc[0][0]), 67'(t + 3));
      check("t3_m1_ack_cyc", 67'(ack_cyc[0][1]), 67'(t + 6));
    end
    check("t3_order_len", 67'(strobe_log.size()), 67'(4));
    if (strobe_log.size() == 4)
      check("t3_order", 67'({strobe_log[0], strobe_log[1]}), 67'({32'h10, 32'h20}));
    if (strobe_log.size() == 4)
      check("t3_order2", 67'({strobe_log[2], strobe_log[3]}), 67'({32'h10, 32'h20}));

    // 4: repeated M0 requests while pending
    s0 = strobe_cnt[0]; a0 = ack_cnt[0][0];
    set_cmd(0, 1'b1, 32'h30, 32'h3);
    step(1); addr[0] = 32'h34;
    step(1); addr[0] = 32'h38;
    step(1); req[0] = 1'b0;
    step(8);
    check("t4_strobes", 67'(strobe_cnt[0] - s0), 67'(1));
    check("t4_acks", 67'(ack_cnt[0][0] - a0), 67'(1));
    check("t4_addr", 67'(strobe_addr[0]), 67'(32'h30));

    // 5: reset during WAIT of the latency-3 instance
    a1 = ack_cnt[1][1];
    bdata = 32'h5555_5555;
    set_cmd(1, 1'b0, 32'h40, 32'h0);
    step(1); req[1] = 1'b0;
    step(3); reset = 1'b1;
    step(1); reset = 1'b0; bdata = 32'h0;
    check("t5_outs_zero",
          67'({cs_a[1], bwr_a[1], brd_a[1], busy1_a[1], ack1_a[1], baddr_a[1]}), 67'(0));
    step(8);
    check("t5_no_ack", 67'(ack_cnt[1][1] - a1), 67'(0));
    check("t5_rdata", 67'(rd1_a[1]), 67'(0));
    check("t5_busy", 67'(busy1_a[1]), 67'(0));

    // 6: latency-0 instance, M0 read
    t = cyc;
    set_cmd(0, 1'b0, 32'h0000_000C, 32'h0);
    step(1); req[0] = 1'b0;
    step(1); bdata = 32'hDEAD_BEEF;
    step(1); bdata = 32'h0;
    step(8);
    check("t6_ack_cyc", 67'(ack_cyc[2][0]), 67'(t + 3));
    check("t6_rdata", 67'(ack_rd[2][0]), 67'(32'hDEAD_BEEF));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
